// File: rtl/skip_pacer.sv
// skip_pacer: programmable tick divider plus tick-aligned select/mask commit for the skip ring (optional SKIP_PACER_SCLK_EN adds the oSCLK square wave)
module skip_pacer #(
    parameter int LEN = 16,
    parameter int DIVW = 32,
    parameter logic [LEN-1:0] defSEL = LEN'(1),
    parameter logic [LEN-1:0] defMASK = LEN'(16'b1100110011001100)
) (
    input  logic            iCLK,
    input  logic            iRST_N,
    input  logic            iRUN,
    input  logic [DIVW-1:0] iDIV,
    input  logic [LEN-1:0]  iSEL,
    input  logic [LEN-1:0]  iMASK,
    input  logic            iVALID,
    output logic            oREADY,
    output logic            oTICK,
    output logic            oE,
    output logic [LEN-1:0]  oSEL,
    output logic [LEN-1:0]  oMASK,
    output logic            oRST,
    output logic            oSCLK
);
    typedef enum logic [1:0] {IDLE, PEND, COMMIT} state_t;

    state_t state, state_nx;
    logic [DIVW-1:0] cnt, div_q;
    logic [LEN-1:0] shadow_sel, shadow_mask;
    logic wrap;

    assign wrap = iRUN && (cnt == div_q);
    assign oREADY = (state == IDLE);
    assign oRST = (state == COMMIT);

    // divider: count to the latched terminal, reload terminal only at wrap
    always_ff @(posedge iCLK or negedge iRST_N)
        if (!iRST_N) begin
            cnt <= '0;
            div_q <= '0;
            oTICK <= 1'b0;
            oE <= 1'b0;
        end else begin
            cnt <= wrap ? '0 : (iRUN ? cnt + DIVW'(1) : cnt);
            div_q <= wrap ? iDIV : div_q;
            oTICK <= wrap;
            oE <= iRUN;
        end

    // pattern FSM state register
    always_ff @(posedge iCLK or negedge iRST_N)
        if (!iRST_N)
            state <= IDLE;
        else
            state <= state_nx;

    // accept in IDLE, wait for a wrap in PEND, hold ring reset for one cycle in COMMIT
    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (iVALID) state_nx = PEND;
            PEND:    if (wrap) state_nx = COMMIT;
            default: state_nx = IDLE;
        endcase
    end

    // shadow capture on handshake; committed pattern updated on the wrap that leaves PEND
    always_ff @(posedge iCLK or negedge iRST_N)
        if (!iRST_N) begin
            shadow_sel <= defSEL;
            shadow_mask <= defMASK;
            oSEL <= defSEL;
            oMASK <= defMASK;
        end else begin
            if (iVALID && state == IDLE) begin
                shadow_sel <= iSEL;
                shadow_mask <= iMASK;
            end
            if (state == PEND && wrap) begin
                oSEL <= (shadow_sel == '0) ? defSEL : shadow_sel;
                oMASK <= shadow_mask;
            end
        end

`ifdef SKIP_PACER_SCLK_EN
    // square-wave tick clock: toggle on every wrap
    always_ff @(posedge iCLK or negedge iRST_N)
        if (!iRST_N)
            oSCLK <= 1'b0;
        else if (wrap)
            oSCLK <= ~oSCLK;
`else
    assign oSCLK = 1'b0;
`endif
endmodule
